// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : FIFO-buffered UART transmitter, single clock domain. CPU writes
//            are queued and serialised as start / data (LSB first) /
//            optional parity / stop bits, with back-to-back frames when the
//            FIFO stays non-empty.
// Revision : 1.0  initial release
// ============================================================================
module uart_tx_fifo #(
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int CW           = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          areset,
  input  logic          WE,
  input  logic [7:0]    wd_data,
  input  logic          ovf_clr,
  output logic          tx_serial,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic          busy,
  output logic          overflow
);

  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_BITS);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic [CW-1:0]     CNT_FULL  = CW'(FIFO_DEPTH);
  // Only the low DATA_BITS of a word take part in the parity calculation.
  localparam logic [7:0]        DATA_MASK = 8'((1 << DATA_BITS) - 1);
  localparam logic              PAR_ODD   = (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  // Storage keeps the full byte; bits above DATA_BITS simply never reach the line.
  logic [7:0]        mem_q [FIFO_DEPTH];

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              ovf_q, ovf_d;

  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;

  logic              push;
  logic              pop;
  logic              baud_end;
  logic              stop_end;
  logic [7:0]        head;

  // Handshake decisions, all taken from pre-edge registered flags.
  always_comb begin
    head     = mem_q[rd_ptr_q];
    baud_end = (baud_q == BAUD_LAST);
    stop_end = (state_q == S_STOP) && baud_end && (bit_q == STOP_LAST);
    push     = WE && !full_q;
    pop      = !empty_q && ((state_q == S_IDLE) || stop_end);
  end

  // FIFO bookkeeping: pointers, occupancy, flags and the sticky overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
    full_d   = (count_d == CNT_FULL);
    empty_d  = (count_d == '0);
    if (WE && full_q) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Serialiser next-state: a pop always lands in START with the line low.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        tx_d   = 1'b1;
      end
      S_START: begin
        if (baud_end) begin
          state_d = S_DATA;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
            if (PARITY != 0) begin
              state_d = S_PAR;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_PAR: begin
        if (baud_end) begin
          state_d = S_STOP;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == STOP_LAST) begin
            bit_d   = '0;
            state_d = S_IDLE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
        tx_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
        bit_d   = '0;
        tx_d    = 1'b1;
      end
    endcase
    // Loading a word overrides the per-state result (IDLE or last stop cycle).
    if (pop) begin
      state_d = S_START;
      baud_d  = '0;
      bit_d   = '0;
      shift_d = head;
      par_d   = (^(head & DATA_MASK)) ^ PAR_ODD;
      tx_d    = 1'b0;
    end
    busy_d = (state_d != S_IDLE);
  end

  // FIFO storage array; contents need no reset because pointers gate access.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wd_data;
    end
  end

  // State registers with synchronous reset; a reset mid-frame idles the line.
  always_ff @(posedge clk) begin
    if (areset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
    end
  end

  assign tx_serial = tx_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign count     = count_q;
  assign busy      = busy_q;
  assign overflow  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Purpose  : Self-checking bench for uart_tx_fifo. Four configurations share
//            one stimulus stream; a waveform-queue reference model predicts
//            the line level and FIFO status every cycle.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_fifo;

  localparam int N   = 4;
  localparam int CPB = 4;
  localparam int DB  [N] = '{8, 8, 8, 5};
  localparam int PAR [N] = '{0, 1, 2, 0};
  localparam int SB  [N] = '{1, 1, 1, 2};
  localparam int DEP [N] = '{4, 4, 4, 8};

  logic       clk = 1'b0;
  logic       areset = 1'b1;
  logic       we = 1'b0;
  logic [7:0] wd = 8'h00;
  logic       ovf_clr = 1'b0;

  logic       tx_a    [N];
  logic       full_a  [N];
  logic       empty_a [N];
  logic       busy_a  [N];
  logic       ovf_a   [N];
  logic [3:0] cnt_a   [N];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int busy_cnt [N];

  // Reference model: pending FIFO words and the expected line level for
  // every future cycle of the frame(s) already started.
  logic [7:0] mq [N][$];
  bit         ml [N][$];
  bit         movf [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    uart_tx_fifo #(
      .DATA_BITS   (DB[g]),
      .FIFO_DEPTH  (DEP[g]),
      .CLKS_PER_BIT(CPB),
      .PARITY      (PAR[g]),
      .STOP_BITS   (SB[g]),
      .CW          (4)
    ) u_dut (
      .clk      (clk),
      .areset   (areset),
      .WE       (we),
      .wd_data  (wd),
      .ovf_clr  (ovf_clr),
      .tx_serial(tx_a[g]),
      .full     (full_a[g]),
      .empty    (empty_a[g]),
      .count    (cnt_a[g]),
      .busy     (busy_a[g]),
      .overflow (ovf_a[g])
    );
  end

  task automatic check(input string tag, input int k, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] cycle %0d: observed=%0h expected=%0h", tag, k, cyc, obs, exp);
    end
  endtask

  // Append the full expected waveform of one frame for configuration k.
  task automatic add_frame(input int k, input logic [7:0] w);
    bit lvl [$];
    bit p;
    lvl.push_back(1'b0);
    p = 1'b0;
    for (int i = 0; i < DB[k]; i++) begin
      lvl.push_back(w[i]);
      p = p ^ w[i];
    end
    if (PAR[k] == 1) lvl.push_back(p);
    if (PAR[k] == 2) lvl.push_back(~p);
    for (int s = 0; s < SB[k]; s++) lvl.push_back(1'b1);
    foreach (lvl[i]) begin
      for (int c = 0; c < CPB; c++) ml[k].push_back(lvl[i]);
    end
  endtask

  task automatic model_step(input logic i_we, input logic [7:0] i_d, input logic i_clr,
                            input logic i_rst);
    for (int k = 0; k < N; k++) begin
      if (i_rst) begin
        mq[k].delete();
        ml[k].delete();
        movf[k] = 1'b0;
      end else begin
        bit do_pop;
        bit do_push;
        logic [7:0] w;
        // A word is taken when the line is idle or in its final stop cycle.
        do_pop  = (mq[k].size() != 0) && (ml[k].size() <= 1);
        do_push = i_we && (mq[k].size() < DEP[k]);
        if (i_we && !do_push) movf[k] = 1'b1;
        else if (i_clr)       movf[k] = 1'b0;
        if (ml[k].size() != 0) void'(ml[k].pop_front());
        if (do_pop) begin
          w = mq[k].pop_front();
          add_frame(k, w);
        end
        if (do_push) mq[k].push_back(i_d);
      end
    end
  endtask

  task automatic step(input logic i_we, input logic [7:0] i_d, input logic i_clr,
                      input logic i_rst);
    we      = i_we;
    wd      = i_d;
    ovf_clr = i_clr;
    areset  = i_rst;
    @(posedge clk);
    model_step(i_we, i_d, i_clr, i_rst);
    cyc++;
    #1;
    for (int k = 0; k < N; k++) begin
      check("tx_serial", k, 32'(tx_a[k]), 32'((ml[k].size() != 0) ? ml[k][0] : 1'b1));
      check("count",     k, 32'(cnt_a[k]), 32'(mq[k].size()));
      check("full",      k, 32'(full_a[k]), 32'(mq[k].size() == DEP[k]));
      check("empty",     k, 32'(empty_a[k]), 32'(mq[k].size() == 0));
      check("busy",      k, 32'(busy_a[k]), 32'(ml[k].size() != 0));
      check("overflow",  k, 32'(ovf_a[k]), 32'(movf[k]));
      if (busy_a[k] === 1'b1) busy_cnt[k]++;
    end
  endtask

  task automatic clear_busy();
    for (int k = 0; k < N; k++) busy_cnt[k] = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset and settle.
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    idle(3);

    // Single frames: busy length equals the frame length of each config.
    clear_busy();
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    idle(59);
    check("busy_len_a5", 0, busy_cnt[0], 40);
    check("busy_len_a5", 1, busy_cnt[1], 44);
    check("busy_len_a5", 2, busy_cnt[2], 44);
    check("busy_len_a5", 3, busy_cnt[3], 32);

    clear_busy();
    step(1'b1, 8'h07, 1'b0, 1'b0);
    idle(59);
    check("busy_len_07", 1, busy_cnt[1], 44);
    check("busy_len_07", 2, busy_cnt[2], 44);

    step(1'b1, 8'h3F, 1'b0, 1'b0);
    idle(50);

    // Overflow: six back-to-back writes into a depth-4 FIFO.
    clear_busy();
    for (int i = 1; i <= 6; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    check("ovf_set", 0, 32'(ovf_a[0]), 32'd1);
    check("ovf_set", 3, 32'(ovf_a[3]), 32'd0);
    idle(220);
    check("busy_len_5w", 0, busy_cnt[0], 200);
    check("busy_len_6w", 3, busy_cnt[3], 192);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("ovf_clr", 0, 32'(ovf_a[0]), 32'd0);

    // Back-to-back pair must be gapless.
    clear_busy();
    step(1'b1, 8'h55, 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    idle(100);
    check("busy_len_b2b", 0, busy_cnt[0], 80);
    check("busy_len_b2b", 3, busy_cnt[3], 64);

    // Reset during data bit 3 of 0xFF with two more words queued.
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    idle(16);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("rst_tx",    0, 32'(tx_a[0]), 32'd1);
    check("rst_count", 0, 32'(cnt_a[0]), 32'd0);
    check("rst_empty", 0, 32'(empty_a[0]), 32'd1);
    check("rst_busy",  0, 32'(busy_a[0]), 32'd0);
    clear_busy();
    idle(60);
    check("rst_no_frames", 0, busy_cnt[0], 0);

    // Randomised traffic at light and heavy write rates.
    for (int i = 0; i < 2400; i++) begin
      int rate;
      rate = (i < 1200) ? 50 : 6;
      step(($urandom_range(0, rate - 1) == 0), 8'($urandom),
           ($urandom_range(0, 39) == 0), ($urandom_range(0, 799) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
